// File: rtl/tsn_rcc_responder.sv
// Gemmini-side read-control responder: splits rcc commands into 128-bit memory
// reads and returns the data as tagged rcd beats in command order.
module tsn_rcc_responder #(
  parameter int CMD_DEPTH  = 4,
  parameter int RESP_DEPTH = 8
) (
  input  logic         gemmini_clk,
  input  logic         reset,
  input  logic [39:0]  rcc_dram_addr,
  input  logic [15:0]  rcc_dpram_addr,
  input  logic [15:0]  rcc_length,
  input  logic         rcc_valid,
  output logic         rcc_ready,
  output logic [15:0]  rcd_dpram_addr,
  output logic [127:0] rcd_read_data,
  output logic [15:0]  rcd_length,
  output logic         rcd_valid,
  input  logic         rcd_ready,
  output logic [39:0]  mem_req_addr,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  input  logic [127:0] mem_resp_data,
  input  logic         mem_resp_valid,
  output logic         busy
);

  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RESP_DEPTH);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;
  localparam logic [CW:0] CMD_FULL   = (CW+1)'(CMD_DEPTH);
  localparam logic [RW:0] CREDIT_MAX = (RW+1)'(RESP_DEPTH);

  logic [71:0]   cmd_mem_q  [CMD_DEPTH];
  logic [31:0]   tag_mem_q  [CMD_DEPTH];
  logic [127:0]  resp_mem_q [RESP_DEPTH];

  logic [CW-1:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [CW:0]   cmd_cnt_q, cmd_cnt_d;
  logic [CW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [CW:0]   tag_cnt_q, tag_cnt_d;
  logic [RW-1:0] resp_wp_q, resp_wp_d, resp_rp_q, resp_rp_d;
  logic [RW:0]   resp_cnt_q, resp_cnt_d;

  logic [0:0]    state_q, state_d;
  logic [39:0]   addr_q, addr_d;
  logic [15:0]   remain_q, remain_d;
  logic [RW:0]   credit_q, credit_d;
  logic [15:0]   beat_idx_q, beat_idx_d;
  logic          rcc_ready_q, rcc_ready_d;
  logic          mem_req_valid_q, mem_req_valid_d;
  logic          busy_q, busy_d;

  logic          cmd_push, cmd_pop, tag_push, tag_pop, req_hs, rcd_hs;
  logic [71:0]   cmd_head;
  logic [31:0]   tag_head;

  always_comb begin
    cmd_head  = cmd_mem_q[cmd_rp_q];
    tag_head  = tag_mem_q[tag_rp_q];
    cmd_push  = rcc_valid && rcc_ready_q;
    cmd_pop   = (state_q == S_IDLE) && (cmd_cnt_q != '0) && (tag_cnt_q != CMD_FULL);
    tag_push  = cmd_pop && (cmd_head[15:0] != 16'd0);
    req_hs    = mem_req_valid_q && mem_req_ready;
    rcd_valid = (resp_cnt_q != '0) && (tag_cnt_q != '0);
    rcd_hs    = rcd_valid && rcd_ready;
    tag_pop   = rcd_hs && (beat_idx_q == tag_head[15:0] - 16'd1);

    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    case (state_q)
      S_IDLE: begin
        if (tag_push) begin
          addr_d   = cmd_head[71:32];
          remain_d = cmd_head[15:0];
          state_d  = S_ISSUE;
        end
      end
      default: begin
        if (req_hs) begin
          addr_d   = addr_q + 40'd16;
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) state_d = S_IDLE;
        end
      end
    endcase

    // credit tracks free response-FIFO slots, so outstanding reads can never overflow it
    credit_d   = credit_q - {{RW{1'b0}}, req_hs} + {{RW{1'b0}}, rcd_hs};

    beat_idx_d = beat_idx_q;
    if (rcd_hs) beat_idx_d = tag_pop ? 16'd0 : beat_idx_q + 16'd1;

    cmd_wp_d   = cmd_wp_q + CW'(cmd_push);
    cmd_rp_d   = cmd_rp_q + CW'(cmd_pop);
    cmd_cnt_d  = cmd_cnt_q + (CW+1)'(cmd_push) - (CW+1)'(cmd_pop);
    tag_wp_d   = tag_wp_q + CW'(tag_push);
    tag_rp_d   = tag_rp_q + CW'(tag_pop);
    tag_cnt_d  = tag_cnt_q + (CW+1)'(tag_push) - (CW+1)'(tag_pop);
    resp_wp_d  = resp_wp_q + RW'(mem_resp_valid);
    resp_rp_d  = resp_rp_q + RW'(rcd_hs);
    resp_cnt_d = resp_cnt_q + (RW+1)'(mem_resp_valid) - (RW+1)'(rcd_hs);

    rcc_ready_d     = (cmd_cnt_d != CMD_FULL);
    mem_req_valid_d = (state_d == S_ISSUE) && (credit_d != '0);
    busy_d          = (cmd_cnt_d != '0) || (tag_cnt_d != '0) || (state_d == S_ISSUE);
  end

  always_ff @(posedge gemmini_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CMD_DEPTH; i++) begin
        cmd_mem_q[i] <= '0;
        tag_mem_q[i] <= '0;
      end
      for (int i = 0; i < RESP_DEPTH; i++) resp_mem_q[i] <= '0;
      cmd_wp_q        <= '0;
      cmd_rp_q        <= '0;
      cmd_cnt_q       <= '0;
      tag_wp_q        <= '0;
      tag_rp_q        <= '0;
      tag_cnt_q       <= '0;
      resp_wp_q       <= '0;
      resp_rp_q       <= '0;
      resp_cnt_q      <= '0;
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      credit_q        <= CREDIT_MAX;
      beat_idx_q      <= '0;
      rcc_ready_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      if (cmd_push)       cmd_mem_q[cmd_wp_q]   <= {rcc_dram_addr, rcc_dpram_addr, rcc_length};
      if (tag_push)       tag_mem_q[tag_wp_q]   <= cmd_head[31:0];
      if (mem_resp_valid) resp_mem_q[resp_wp_q] <= mem_resp_data;
      cmd_wp_q        <= cmd_wp_d;
      cmd_rp_q        <= cmd_rp_d;
      cmd_cnt_q       <= cmd_cnt_d;
      tag_wp_q        <= tag_wp_d;
      tag_rp_q        <= tag_rp_d;
      tag_cnt_q       <= tag_cnt_d;
      resp_wp_q       <= resp_wp_d;
      resp_rp_q       <= resp_rp_d;
      resp_cnt_q      <= resp_cnt_d;
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      credit_q        <= credit_d;
      beat_idx_q      <= beat_idx_d;
      rcc_ready_q     <= rcc_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      busy_q          <= busy_d;
    end
  end

  assign rcc_ready      = rcc_ready_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = addr_q;
  assign busy           = busy_q;
  assign rcd_read_data  = resp_mem_q[resp_rp_q];
  assign rcd_dpram_addr = tag_head[31:16] + beat_idx_q;
  assign rcd_length     = tag_head[15:0];

endmodule
